// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding fetch request to
// instruction memory and loads the IF/ID pipeline registers. It handles
// decode stalls through a one-entry capture buffer and redirects the PC
// on taken branches.
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        freeze,
    input  logic        brTaken,
    input  logic [31:0] br_imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc_out_r;
    logic        valid_r;
    logic [31:0] buf_r;
    logic        req_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] br_target_s;
    logic        redirect_s;

    // Next sequential PC, the branch target and the redirect qualifier.
    // A branch is only acted on when decode holds a real instruction and is not stalled.
    always_comb begin
        pc_plus4_s  = pc_r + 32'd4;
        br_target_s = pc_out_r + {br_imm[29:0], 2'b00};
        redirect_s  = brTaken & ~freeze & valid_r;
    end

    // Fetch FSM, PC, capture buffer and IF/ID registers.
    // The request flag is registered alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            pc_r     <= 32'd0;
            instr_r  <= 32'd0;
            pc_out_r <= 32'd0;
            valid_r  <= 1'b0;
            buf_r    <= 32'd0;
            req_r    <= 1'b0;
        end else if (redirect_s) begin
            // Redirect wins over everything else. The word acked this cycle is dropped.
            state_r <= FETCH;
            pc_r    <= br_target_s;
            instr_r <= 32'd0;
            valid_r <= 1'b0;
            buf_r   <= 32'd0;
            req_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (imem_ack && !freeze) begin
                        instr_r  <= imem_rdata;
                        pc_out_r <= pc_plus4_s;
                        valid_r  <= 1'b1;
                        pc_r     <= pc_plus4_s;
                    end else if (imem_ack && freeze) begin
                        // Park the returned word until decode releases the stall.
                        buf_r   <= imem_rdata;
                        state_r <= STALL;
                        req_r   <= 1'b0;
                    end else if (!imem_ack && !freeze) begin
                        instr_r <= 32'd0;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                STALL: begin
                    if (!freeze) begin
                        instr_r  <= buf_r;
                        pc_out_r <= pc_plus4_s;
                        valid_r  <= 1'b1;
                        pc_r     <= pc_plus4_s;
                        state_r  <= FETCH;
                        req_r    <= 1'b1;
                    end else begin
                        state_r <= STALL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instruction = instr_r;
    assign pc_out      = pc_out_r;
    assign if_valid    = valid_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        freeze;
    logic        brTaken;
    logic [31:0] br_imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        if_valid;

    int tests_run;
    int tests_failed;

    // Behavioural model: the fetcher is either off or running; while running
    // it may hold one parked word that decode has not yet taken.
    bit          m_running;
    bit          m_parked;
    logic [31:0] m_park_word;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;
    bit          m_valid;

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .freeze     (freeze),
        .brTaken    (brTaken),
        .br_imm     (br_imm),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .pc_out     (pc_out),
        .if_valid   (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    // Apply the fetch rules to the model for one clock edge with the current inputs.
    task automatic model_edge();
        if (rst) begin
            m_running = 0; m_parked = 0; m_park_word = 32'd0;
            m_pc = 32'd0; m_instr = 32'd0; m_pc_out = 32'd0; m_valid = 0;
        end else if (brTaken && !freeze && m_valid) begin
            m_pc = m_pc_out + br_imm * 32'd4;
            m_instr = 32'd0; m_valid = 0; m_parked = 0; m_running = 1;
        end else if (!m_running) begin
            if (start) m_running = 1;
        end else if (m_parked) begin
            if (!freeze) begin
                m_instr = m_park_word; m_pc_out = m_pc + 32'd4; m_valid = 1;
                m_pc = m_pc + 32'd4; m_parked = 0;
            end
        end else if (imem_ack && !freeze) begin
            m_instr = imem_rdata; m_pc_out = m_pc + 32'd4; m_valid = 1;
            m_pc = m_pc + 32'd4;
        end else if (imem_ack && freeze) begin
            m_park_word = imem_rdata; m_parked = 1;
        end else if (!freeze) begin
            m_instr = 32'd0; m_valid = 0;
        end
    endtask

    // One clock: inputs were set at the previous falling edge; come back at the next one.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; freeze = 1'b0; brTaken = 1'b0;
        br_imm = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    endtask

    task automatic do_reset_and_start();
        idle_inputs();
        rst = 1'b1; cycle();
        rst = 1'b0; start = 1'b1; cycle();
        start = 1'b0;
    endtask

    // Zero-wait fetch of the word at the current model PC.
    task automatic ack_word();
        imem_ack = 1'b1; imem_rdata = word(m_pc); cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; cycle();
        rst = 1'b0;
        tests_run++;
        if ({imem_req, imem_addr, instruction, pc_out, if_valid} !== 98'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got req=%0b addr=%h instr=%h pc_out=%h valid=%0b, want all zero",
                     imem_req, imem_addr, instruction, pc_out, if_valid);
        end
        imem_ack = 1'b1; cycle(); cycle();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL idle_no_start: got req=%0b addr=%h, want req=0 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset_and_start();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL stream_first_req: got req=%0b addr=%h, want req=1 addr=0", imem_req, imem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            a = 32'(k) * 32'd4;
            tests_run++;
            if (imem_addr !== a) begin
                tests_failed++;
                $display("FAIL stream_addr[%0d]: got %h, want %h", k, imem_addr, a);
            end
            imem_ack = 1'b1; imem_rdata = word(a); cycle();
            tests_run++;
            if (instruction !== word(a) || pc_out !== a + 32'd4 || if_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ifid[%0d]: got instr=%h pc_out=%h valid=%0b, want %h %h 1",
                         k, instruction, pc_out, if_valid, word(a), a + 32'd4);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset_and_start();
        for (int k = 0; k < 4; k++) ack_word();
        freeze = 1'b1; imem_ack = 1'b1; imem_rdata = word(32'h10);
        for (int k = 0; k < 3; k++) begin
            cycle();
            imem_ack = 1'b0;
            tests_run++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h10 || instruction !== word(32'h0C) ||
                pc_out !== 32'h10 || if_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL freeze_hold[%0d]: got req=%0b addr=%h instr=%h pc_out=%h valid=%0b, want 0 10 %h 10 1",
                         k, imem_req, imem_addr, instruction, pc_out, if_valid, word(32'h0C));
            end
        end
        freeze = 1'b0; cycle();
        tests_run++;
        if (instruction !== word(32'h10) || pc_out !== 32'h14 || if_valid !== 1'b1 ||
            imem_addr !== 32'h14 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_release: got instr=%h pc_out=%h valid=%0b addr=%h req=%0b, want %h 14 1 14 1",
                     instruction, pc_out, if_valid, imem_addr, imem_req, word(32'h10));
        end
    endtask

    task automatic test_branch();
        do_reset_and_start();
        for (int k = 0; k < 9; k++) ack_word();
        tests_run++;
        if (pc_out !== 32'h24) begin
            tests_failed++;
            $display("FAIL branch_setup: got pc_out=%h, want 00000024", pc_out);
        end
        brTaken = 1'b1; br_imm = 32'hFFFF_FFFE; imem_ack = 1'b1; imem_rdata = word(32'h24);
        cycle();
        brTaken = 1'b0; br_imm = 32'd0;
        tests_run++;
        if (imem_addr !== 32'h1C || instruction !== 32'd0 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_redirect: got addr=%h instr=%h valid=%0b req=%0b, want 1c 0 0 1",
                     imem_addr, instruction, if_valid, imem_req);
        end
        imem_ack = 1'b1; imem_rdata = word(32'h1C); cycle();
        tests_run++;
        if (instruction !== word(32'h1C) || pc_out !== 32'h20 || if_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_target_fetch: got instr=%h pc_out=%h valid=%0b, want %h 20 1",
                     instruction, pc_out, if_valid, word(32'h1C));
        end
    endtask

    task automatic test_ack_delay();
        do_reset_and_start();
        ack_word(); ack_word();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            tests_run++;
            if (if_valid !== 1'b0 || instruction !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                tests_failed++;
                $display("FAIL ack_delay_bubble[%0d]: got valid=%0b instr=%h req=%0b addr=%h, want 0 0 1 8",
                         k, if_valid, instruction, imem_req, imem_addr);
            end
        end
        imem_ack = 1'b1; imem_rdata = word(32'h8); cycle();
        tests_run++;
        if (instruction !== word(32'h8) || pc_out !== 32'hC || if_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_delay_resume: got instr=%h pc_out=%h valid=%0b, want %h c 1",
                     instruction, pc_out, if_valid, word(32'h8));
        end
    endtask

    task automatic test_wrap();
        do_reset_and_start();
        ack_word();
        brTaken = 1'b1; br_imm = 32'hFFFF_FFFE; imem_ack = 1'b0; cycle();
        brTaken = 1'b0; br_imm = 32'd0;
        tests_run++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_setup: got addr=%h, want fffffffc", imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = word(32'hFFFF_FFFC); cycle();
        tests_run++;
        if (pc_out !== 32'd0 || imem_addr !== 32'd0 || instruction !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pc: got pc_out=%h addr=%h instr=%h valid=%0b, want 0 0 fffffffc 1",
                     pc_out, imem_addr, instruction, if_valid);
        end
    endtask

    task automatic test_reset_in_stall();
        do_reset_and_start();
        ack_word();
        freeze = 1'b1; ack_word();
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stall_setup: got req=%0b, want 0", imem_req);
        end
        rst = 1'b1; cycle();
        rst = 1'b0; freeze = 1'b0;
        tests_run++;
        if ({imem_req, imem_addr, instruction, pc_out, if_valid} !== 98'd0) begin
            tests_failed++;
            $display("FAIL rst_stall_clear: got req=%0b addr=%h instr=%h pc_out=%h valid=%0b, want all zero",
                     imem_req, imem_addr, instruction, pc_out, if_valid);
        end
        cycle(); cycle();
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stall_idle: got req=%0b valid=%0b, want 0 0", imem_req, if_valid);
        end
        start = 1'b1; cycle();
        start = 1'b0;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_stall_restart: got req=%0b addr=%h, want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [97:0] want;
        do_reset_and_start();
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 79) == 0);
            start      = ($urandom_range(0, 3) == 0);
            freeze     = ($urandom_range(0, 3) == 0);
            brTaken    = ($urandom_range(0, 5) == 0);
            br_imm     = 32'($signed($urandom_range(0, 15)) - 8);
            imem_ack   = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            cycle();
            want = {m_running && !m_parked, m_pc, m_instr, m_pc_out, m_valid};
            tests_run++;
            if ({imem_req, imem_addr, instruction, pc_out, if_valid} !== want) begin
                tests_failed++;
                $display("FAIL random[%0d]: got req=%0b addr=%h instr=%h pc_out=%h valid=%0b, want req=%0b addr=%h instr=%h pc_out=%h valid=%0b",
                         n, imem_req, imem_addr, instruction, pc_out, if_valid,
                         want[97], want[96:65], want[64:33], want[32:1], want[0]);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_stream();
        test_freeze();
        test_branch();
        test_ack_delay();
        test_wrap();
        test_reset_in_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1: begin fetching; sampled only in IDLE.
REQ-004 SHALL have port freeze, input, 1: hazard stall from decode; holds PC and the IF/ID outputs.
REQ-005 SHALL have port brTaken, input, 1: branch resolved taken for the instruction currently in IF/ID.
REQ-006 SHALL have port br_imm, input, 32: sign-extended 16-bit branch immediate of the instruction in IF/ID.
REQ-007 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-008 SHALL have port imem_addr, output, 32: byte address of the fetch; always equals PC.
REQ-009 SHALL have port imem_ack, input, 1: memory returns imem_rdata this cycle; may assert in the same cycle as imem_req.
REQ-010 SHALL have port imem_rdata, input, 32: fetched word; valid only when imem_ack=1.
REQ-011 SHALL have port instruction, output, 32: IF/ID instruction register feeding decode.
REQ-012 SHALL have port pc_out, output, 32: IF/ID register holding PC+4 of the instruction.
REQ-013 SHALL have port if_valid, output, 1: the IF/ID contents are a real instruction (0 = bubble).

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, FETCH and STALL.
REQ-015 SHALL drive imem_req=1 only in FETCH; imem_req=0 in IDLE and STALL.
REQ-016 IDLE: SHALL move to FETCH when start=1, else remain; PC unchanged.
REQ-017 FETCH, imem_ack=1, freeze=0: SHALL load the IF/ID registers.
  - instruction <= imem_rdata; pc_out <= PC+4; if_valid <= 1.
  - PC <= PC+4; remain in FETCH.
REQ-018 FETCH, imem_ack=1, freeze=1: SHALL hold PC and IF/ID, capture imem_rdata in a one-entry buffer, and go to STALL.
REQ-019 FETCH, imem_ack=0, freeze=0: SHALL insert a bubble (instruction <= 0, if_valid <= 0; pc_out unchanged) and hold PC.
REQ-020 FETCH, imem_ack=0, freeze=1: SHALL hold all registers.
REQ-021 STALL, freeze=0: SHALL perform the following, then return to FETCH.
  - instruction <= buffer; pc_out <= PC+4; if_valid <= 1; PC <= PC+4.
REQ-022 STALL, freeze=1: SHALL hold all registers.
REQ-023 brTaken=1 with freeze=0 and if_valid=1 SHALL have priority over REQ-017 to REQ-022.
  - PC <= pc_out + (br_imm << 2), modulo 2^32.
  - instruction <= 0; if_valid <= 0; buffer discarded.
  - Any imem_rdata acked in that cycle is dropped; state <= FETCH.
REQ-024 SHALL ignore brTaken when freeze=1 or if_valid=0.
REQ-025 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 The PC SHALL always be word-aligned (bits [1:0] = 0).
REQ-027 Fetch-to-decode latency SHALL be one cycle: a word acked in cycle N appears on instruction in cycle N+1.
REQ-028 imem_addr SHALL change only after an ack or on a branch redirect.
REQ-029 SHALL support at most one outstanding request at any time.

Reset
REQ-030 rst=1 SHALL, at the next rising edge, override all other inputs, including reset mid-fetch or mid-stall.
  - PC <= 0; instruction <= 0; pc_out <= 0; if_valid <= 0; buffer <= 0.
  - State <= IDLE; imem_req = 0.
REQ-031 After reset is released, the block SHALL stay in IDLE with no request until start=1.

Verification
REQ-032 Start with zero-wait memory (ack always 1; rdata = 0xA0000000 | addr) -> from the cycle after start, imem_addr = 0, 4, 8, ... and each instruction appears one cycle later with pc_out = addr+4 and if_valid=1.
REQ-033 freeze=1 for 3 cycles while the word at 0x10 is acked -> PC stays 0x10, IF/ID holds its prior instruction, imem_req=0 in STALL; after release, instruction = word(0x10), pc_out = 0x14.
REQ-034 brTaken=1 with pc_out = 0x24 and br_imm = 0xFFFFFFFE -> next imem_addr = 0x1C; the cycle after, instruction = 0 and if_valid = 0; the word acked in the redirect cycle never reaches decode.
REQ-035 ack delayed 2 cycles -> two bubbles (if_valid=0, instruction=0), imem_req held high, imem_addr stable.
REQ-036 PC = 0xFFFFFFFC acked -> pc_out = 0x00000000 and the next imem_addr = 0.
REQ-037 rst=1 asserted during STALL -> next cycle all outputs are 0 and state is IDLE; start is required to resume fetching from address 0.
